// File: rtl/thermo_dwa.sv
// DWA element rotator: counts the ones in a thermometer code and re-maps them
// onto a rotating window of unit elements so element mismatch is first-order shaped.
`timescale 1ns/1ps
module thermo_dwa #(
  parameter int D_WIDTH = 4,
  parameter int Q_WIDTH = 2**D_WIDTH
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               DWA_EN,
  input  logic               VALID_IN,
  input  logic [Q_WIDTH-1:0] Q_IN,
  input  logic               CLR_ERR,
  output logic [Q_WIDTH-1:0] Q_OUT,
  output logic               VALID_OUT,
  output logic [D_WIDTH-1:0] PTR,
  output logic               ERR
);

  localparam int NW = D_WIDTH + 1;

  // Stage-1 registers
  logic               s1_valid_q, s1_valid_d;
  logic               s1_ok_q,    s1_ok_d;
  logic [NW-1:0]      s1_n_q,     s1_n_d;
  logic [Q_WIDTH-1:0] s1_code_q,  s1_code_d;
  logic               s1_en_q,    s1_en_d;

  // Stage-2 registers
  logic [Q_WIDTH-1:0] q_out_q,     q_out_d;
  logic               valid_out_q, valid_out_d;
  logic [D_WIDTH-1:0] ptr_q,       ptr_d;
  logic               err_q,       err_d;

  logic [NW-1:0]      n_in;
  logic               code_ok;
  logic [Q_WIDTH-1:0] mask;
  logic [Q_WIDTH-1:0] rot;
  logic [D_WIDTH-1:0] idx;

  // Stage 1: popcount, bubble check, capture
  always_comb begin
    n_in = '0;
    for (int unsigned i = 0; i < Q_WIDTH; i++) begin
      n_in = n_in + NW'(Q_IN[i]);
    end
    // A bubble is any one sitting directly below a zero.
    code_ok = ~|(Q_IN[Q_WIDTH-2:0] & ~Q_IN[Q_WIDTH-1:1]);

    s1_valid_d = VALID_IN;
    s1_ok_d    = s1_ok_q;
    s1_n_d     = s1_n_q;
    s1_code_d  = s1_code_q;
    s1_en_d    = s1_en_q;
    if (VALID_IN) begin
      s1_ok_d   = code_ok;
      s1_n_d    = n_in;
      s1_code_d = Q_IN;
      s1_en_d   = DWA_EN;
    end
  end

  // Stage 2: rotate an N-wide mask by PTR and advance the pointer
  always_comb begin
    mask = ~({Q_WIDTH{1'b1}} << s1_n_q);
    rot  = '0;
    idx  = '0;
    for (int unsigned i = 0; i < Q_WIDTH; i++) begin
      idx    = D_WIDTH'(i) - ptr_q;
      rot[i] = mask[idx];
    end

    q_out_d     = q_out_q;
    ptr_d       = ptr_q;
    valid_out_d = s1_valid_q;
    err_d       = err_q & ~CLR_ERR;
    if (s1_valid_q) begin
      if (!s1_ok_q) begin
        q_out_d = '0;
        err_d   = 1'b1;
      end else if (s1_en_q) begin
        q_out_d = rot;
        // N = Q_WIDTH has all-zero low bits, so the truncated add is the full wrap.
        ptr_d   = ptr_q + s1_n_q[D_WIDTH-1:0];
      end else begin
        q_out_d = s1_code_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_n_q      <= '0;
      s1_code_q   <= '0;
      s1_en_q     <= 1'b0;
      q_out_q     <= '0;
      valid_out_q <= 1'b0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ok_q     <= s1_ok_d;
      s1_n_q      <= s1_n_d;
      s1_code_q   <= s1_code_d;
      s1_en_q     <= s1_en_d;
      q_out_q     <= q_out_d;
      valid_out_q <= valid_out_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign Q_OUT     = q_out_q;
  assign VALID_OUT = valid_out_q;
  assign PTR       = ptr_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_thermo_dwa.sv
// Scoreboard bench for thermo_dwa: directed scenarios plus a randomized run
// checked against an arithmetic reference model of the rotator.
`timescale 1ns/1ps
module tb_thermo_dwa;

  localparam int DW = 4;
  localparam int QW = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          DWA_EN = 1'b0;
  logic          VALID_IN = 1'b0;
  logic [QW-1:0] Q_IN = '0;
  logic          CLR_ERR = 1'b0;
  logic [QW-1:0] Q_OUT;
  logic          VALID_OUT;
  logic [DW-1:0] PTR;
  logic          ERR;

  thermo_dwa #(.D_WIDTH(DW), .Q_WIDTH(QW)) dut (
    .CLK(CLK), .RST_N(RST_N), .DWA_EN(DWA_EN), .VALID_IN(VALID_IN),
    .Q_IN(Q_IN), .CLR_ERR(CLR_ERR), .Q_OUT(Q_OUT), .VALID_OUT(VALID_OUT),
    .PTR(PTR), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] q;
    int          ptr;
    bit          bad;
  } exp_t;

  exp_t sb[$];
  int   m_ptr = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The n most significant bits set: the only legal thermometer code with n ones.
  function automatic logic [15:0] top_ones(input int n);
    logic [31:0] t;
    t = 32'h0000_FFFF << (16 - n);
    return t[15:0];
  endfunction

  function automatic exp_t model(input logic [15:0] q, input bit en);
    exp_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 16; i++) if (q[i]) n++;
    e.bad = (q != top_ones(n));
    e.q   = '0;
    if (!e.bad) begin
      if (!en) e.q = q;
      else begin
        for (int k = 0; k < n; k++) e.q[(m_ptr + k) % 16] = 1'b1;
        m_ptr = (m_ptr + n) % 16;
      end
    end
    e.ptr = m_ptr;
    return e;
  endfunction

  task automatic issue(input logic [15:0] q, input bit en);
    Q_IN     = q;
    DWA_EN   = en;
    VALID_IN = 1'b1;
    sb.push_back(model(q, en));
    @(posedge CLK);
    #1;
  endtask

  task automatic one(input string name, input logic [15:0] q, input bit en,
                     input logic [15:0] eq, input int ep);
    issue(q, en);
    VALID_IN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk({name, " q_out"}, Q_OUT, eq);
    chk({name, " ptr"}, PTR, ep);
    chk({name, " valid"}, VALID_OUT, 1);
  endtask

  // Monitor: pops the scoreboard on every VALID_OUT, checks hold otherwise.
  initial begin
    exp_t        e;
    logic [15:0] last_q;
    int          last_ptr;
    bit          exp_err, clr_s, rst_s;
    last_q = '0; last_ptr = 0; exp_err = 1'b0;
    forever begin
      @(posedge CLK);
      clr_s = CLR_ERR;
      rst_s = RST_N;
      @(negedge CLK);
      if (!RST_N || !rst_s) begin
        last_q = '0; last_ptr = 0; exp_err = 1'b0;
        continue;
      end
      exp_err = exp_err && !clr_s;
      if (VALID_OUT) begin
        if (sb.size() == 0) begin
          chk("sb spurious valid_out", VALID_OUT, 0);
        end else begin
          e        = sb.pop_front();
          last_q   = e.q;
          last_ptr = e.ptr;
          exp_err  = exp_err || e.bad;
        end
      end
      chk("sb q_out", Q_OUT, last_q);
      chk("sb ptr", PTR, last_ptr);
      chk("sb err", ERR, exp_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    logic [15:0] q;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset q_out", Q_OUT, 0);
    chk("reset valid", VALID_OUT, 0);
    chk("reset ptr", PTR, 0);
    chk("reset err", ERR, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Back-to-back rotate and wrap
    issue(16'hFFF0, 1);
    issue(16'hFF00, 1);
    VALID_IN = 1'b0;
    @(negedge CLK);
    chk("rot12 q_out", Q_OUT, 16'h0FFF);
    chk("rot12 ptr", PTR, 12);
    @(negedge CLK);
    chk("wrap8 q_out", Q_OUT, 16'hF00F);
    chk("wrap8 ptr", PTR, 4);
    chk("wrap8 valid", VALID_OUT, 1);

    // Extremes
    one("full", 16'hFFFF, 1, 16'hFFFF, 4);
    one("empty", 16'h0000, 1, 16'h0000, 4);
    one("msb", 16'h8000, 1, 16'h0010, 5);

    // Bubble codes and sticky ERR
    one("bubble", 16'hF0F0, 1, 16'h0000, 5);
    chk("bubble err", ERR, 1);
    one("post-bubble", 16'hC000, 1, 16'h0060, 7);
    chk("err sticky", ERR, 1);
    issue(16'hF0F0, 1);
    VALID_IN = 1'b0;
    CLR_ERR  = 1'b1;
    @(posedge CLK); #1;
    CLR_ERR  = 1'b0;
    @(negedge CLK);
    chk("clr+bubble err", ERR, 1);
    chk("clr+bubble q_out", Q_OUT, 0);
    chk("clr+bubble ptr", PTR, 7);
    CLR_ERR = 1'b1;
    @(posedge CLK); #1;
    CLR_ERR = 1'b0;
    @(negedge CLK);
    chk("clr err", ERR, 0);

    // Bypass then re-enable from frozen pointer
    one("bypass", 16'hFFC0, 0, 16'hFFC0, 7);
    one("re-enable", 16'hFFC0, 1, 16'hFF81, 1);

    // Idle hold
    repeat (5) begin
      @(negedge CLK);
      chk("idle valid", VALID_OUT, 0);
      chk("idle q_out", Q_OUT, 16'hFF81);
      chk("idle ptr", PTR, 1);
    end

    // Reset with codes in flight
    issue(16'hFF00, 1);
    issue(16'hF000, 1);
    RST_N    = 1'b0;
    VALID_IN = 1'b0;
    sb.delete();
    m_ptr = 0;
    #1;
    chk("async rst q_out", Q_OUT, 0);
    chk("async rst valid", VALID_OUT, 0);
    chk("async rst ptr", PTR, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("post-rst no valid", VALID_OUT, 0);
    end
    one("post-rst first", 16'hE000, 1, 16'h0007, 3);

    // Randomized stream
    for (int i = 0; i < 10000; i++) begin
      CLR_ERR = ($urandom_range(0, 31) == 0);
      n = $urandom_range(0, 16);
      q = ($urandom_range(0, 7) == 0) ? 16'($urandom) : top_ones(n);
      issue(q, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        VALID_IN = 1'b0;
        CLR_ERR  = ($urandom_range(0, 7) == 0);
        @(posedge CLK); #1;
      end
    end
    VALID_IN = 1'b0;
    CLR_ERR  = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge CLK);
      t++;
    end
    @(negedge CLK);
    chk("drain scoreboard", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thermo_dwa.md
# thermo_dwa

Data-weighted-averaging (DWA) element rotator. It sits directly downstream of the binary-to-thermometer encoder in the segmented unit-element DAC path. It accepts the encoder's thermometer word, counts the asserted units, and re-maps them onto a rotating window of physical elements so that element mismatch is first-order noise-shaped. The result drives the unit-element switch bank through a 2-stage registered pipeline.

## Interface
- D_WIDTH, 4, width of the binary code upstream of the encoder; also the pointer width.
- Q_WIDTH, 2**D_WIDTH, number of unit elements (thermometer width).
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset. Single clock domain.
- DWA_EN  input  1  1 = rotate; 0 = bypass (pass-through, pointer frozen).
- VALID_IN  input  1  Q_IN qualifier; one code accepted per cycle it is high.
- Q_IN  input  Q_WIDTH  thermometer code from the encoder (ones occupy bit Q_WIDTH-1 downward).
- CLR_ERR  input  1  synchronous clear of ERR.
- Q_OUT  output  Q_WIDTH  registered element-select word.
- VALID_OUT  output  1  high for one cycle per accepted code, 2 cycles after VALID_IN.
- PTR  output  D_WIDTH  current rotation pointer (next element to be used).
- ERR  output  1  sticky malformed-code flag.

## Operation
- Stage 1 (on VALID_IN):
  - Register N = popcount(Q_IN), which is D_WIDTH+1 bits wide, range 0..Q_WIDTH.
  - Register the code-valid flag V, the Q_IN copy, DWA_EN, and stage-1 valid.
  - V = 1 iff no i < Q_WIDTH-1 has Q_IN[i]=1 and Q_IN[i+1]=0. This means ones are contiguous and end at the MSB; all-zeros and all-ones are valid.
- Stage 2 (on stage-1 valid):
  - V=0: Q_OUT <= 0, PTR unchanged, ERR <= 1.
  - V=1, DWA_EN=1: Q_OUT[(PTR+k) mod Q_WIDTH] = 1 for k = 0..N-1, all other bits 0. PTR <= (PTR+N) mod Q_WIDTH, computed in D_WIDTH+1 bits and truncated.
  - V=1, DWA_EN=0: Q_OUT <= stored Q_IN, PTR unchanged.
  - VALID_OUT <= 1 in all three cases.
- No stage-1 valid: Q_OUT and PTR hold, VALID_OUT <= 0.
- N = Q_WIDTH: Q_OUT all ones, PTR unchanged (full wrap).
- N = 0: Q_OUT all zeros, PTR unchanged.
- Window wrap: bits PTR..Q_WIDTH-1 and 0..(PTR+N-Q_WIDTH-1) are set.
- ERR stays set until CLR_ERR. If CLR_ERR and a new error occur in the same cycle, set wins.
- DWA_EN is sampled per code in stage 1, so toggling it mid-stream affects only subsequent codes.
- The pointer lives only in stage 2. Back-to-back VALID_IN every cycle is supported; each code rotates from the PTR left by its predecessor.

## Timing
- Reset (RST_N low, asynchronous assert): Q_OUT=0, VALID_OUT=0, PTR=0, ERR=0, all stage-1 registers 0. Deassertion is synchronized externally.
- Latency: code on VALID_IN at edge n → Q_OUT/VALID_OUT valid after edge n+2.
- PTR updates on the same edge as Q_OUT.
- Throughput: 1 code/cycle, no backpressure.
- Reset mid-stream flushes both stages. The first post-reset code rotates from PTR=0.
- Rotation is a single-cycle Q_WIDTH-way barrel rotate of a (2^N − 1) mask. It must close timing at the DAC update clock with no multicycle paths.

## Test plan
All scenarios use D_WIDTH=4, Q_WIDTH=16.
- Rotate and wrap: after reset, VALID_IN with Q_IN=0xFFF0 (N=12) → Q_OUT=0x0FFF, PTR=12. Next code 0xFF00 (N=8) → Q_OUT=0xF00F, PTR=4, both updated in back-to-back cycles.
- Extremes: PTR=4, Q_IN=0xFFFF → Q_OUT=0xFFFF, PTR=4. Then Q_IN=0x0000 → Q_OUT=0x0000, PTR=4. Then Q_IN=0x8000 → Q_OUT=0x0010, PTR=5.
- Bubble code: Q_IN=0xF0F0 → Q_OUT=0, ERR=1, PTR unchanged, VALID_OUT pulses. ERR stays 1 through further valid codes until CLR_ERR. CLR_ERR coincident with a second bubble → ERR remains 1.
- Bypass: DWA_EN=0 with Q_IN=0xFFC0 → Q_OUT=0xFFC0, PTR frozen. Re-enable with the same code → rotated window starting at the frozen PTR.
- Idle hold: VALID_IN low for 5 cycles → Q_OUT and PTR hold, VALID_OUT=0.
- Reset mid-stream: assert RST_N low between two in-flight codes → Q_OUT=0, VALID_OUT=0, PTR=0 immediately (asynchronously), no stale VALID_OUT after release. Random 10k-code run checked against a reference model for PTR and popcount(Q_OUT)=N.
